// File: rtl/burst_write_wf.sv
// burst_write_wf: Avalon-MM burst write master.
// User logic pushes words into a show-ahead FIFO; a control request launches one
// burst of N beats at a base address once the FIFO already holds all N words, so
// master_write never drops in the middle of a burst.
// Optional feature macro: BURST_WRITE_BYTEENABLE_EN adds ctrl_byteenable /
// master_byteenable; without it the slave sees full-word writes.
// Debug: `state` exposes the FSM (0 IDLE, 1 FILL, 2 BURST, 3 DONE).
// Handshake: a beat transfers on any cycle with master_write=1 and
// master_waitrequest=0; while stalled, address/burstcount/writedata hold.
module burst_write_wf #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_COUNT       = 8,
    parameter int BURST_WIDTH       = 4,
    parameter int FIFO_DEPTH        = 16,
    parameter int FIFO_AW           = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_write,
    output logic [DATA_WIDTH-1:0]        master_writedata,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    input  logic                         master_waitrequest,
`ifdef BURST_WRITE_BYTEENABLE_EN
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic [BYTE_ENABLE_WIDTH-1:0] ctrl_byteenable,
`endif
    input  logic                         ctrl_start,
    input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
    input  logic [BURST_WIDTH-1:0]       ctrl_burstcount,
    output logic                         ctrl_busy,
    output logic                         ctrl_done,
    input  logic                         user_write,
    input  logic [DATA_WIDTH-1:0]        user_writedata,
    output logic                         user_buffer_full,
    output logic [FIFO_AW:0]             user_fill_level,
    output logic [1:0]                   state
);

    // Parameter sanity: catches inconsistent derived widths at elaboration.
    if (BYTE_ENABLE_WIDTH * 8 != DATA_WIDTH) begin : g_bad_be_width
        $error("BYTE_ENABLE_WIDTH must equal DATA_WIDTH/8");
    end
    if ((1 << FIFO_AW) != FIFO_DEPTH || FIFO_DEPTH < BURST_COUNT) begin : g_bad_fifo
        $error("FIFO_DEPTH must be 2**FIFO_AW and at least BURST_COUNT");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [FIFO_AW:0]     LEVEL_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [BURST_WIDTH-1:0] MAX_BEATS = BURST_WIDTH'(BURST_COUNT);

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] addr_l;
    logic [BURST_WIDTH-1:0]   count_l;
    logic [BURST_WIDTH-1:0]   beat_cnt;

    logic [DATA_WIDTH-1:0]    mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr;
    logic [FIFO_AW-1:0]       rd_ptr;
    logic [FIFO_AW:0]         level;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     req_ok;
    logic [FIFO_AW:0]         count_ext;

    // A full FIFO still accepts a push when a beat frees a slot in the same cycle.
    assign full      = (level == LEVEL_FULL);
    assign pop       = master_write && !master_waitrequest;
    assign push      = user_write && (!full || pop);
    assign req_ok    = ctrl_start && (ctrl_burstcount != '0) && (ctrl_burstcount <= MAX_BEATS);
    assign count_ext = (FIFO_AW+1)'(count_l);

    // Show-ahead head word; forced to zero when empty so the bus never shows stale data.
    assign master_writedata = (level == '0) ? '0 : mem[rd_ptr];
    assign user_buffer_full = full;
    assign user_fill_level  = level;
    assign state            = state_q;

    // FIFO storage: data only, no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= user_writedata;
        end
    end

    // FIFO pointers and occupancy; reset flushes the contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Burst control FSM with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            addr_l            <= '0;
            count_l           <= '0;
            beat_cnt          <= '0;
            master_address    <= '0;
            master_burstcount <= '0;
            master_write      <= 1'b0;
            ctrl_busy         <= 1'b0;
            ctrl_done         <= 1'b0;
`ifdef BURST_WRITE_BYTEENABLE_EN
            master_byteenable <= '1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // Out-of-range counts are ignored rather than clipped.
                    if (req_ok) begin
                        addr_l    <= ctrl_baseaddress;
                        count_l   <= ctrl_burstcount;
                        beat_cnt  <= '0;
                        ctrl_busy <= 1'b1;
`ifdef BURST_WRITE_BYTEENABLE_EN
                        master_byteenable <= ctrl_byteenable;
`endif
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    // Launch only when every beat of the burst is already buffered.
                    if (level >= count_ext) begin
                        master_write      <= 1'b1;
                        master_address    <= addr_l;
                        master_burstcount <= count_l;
                        state_q           <= BURST;
                    end
                end
                BURST: begin
                    if (!master_waitrequest) begin
                        if (beat_cnt == count_l - BURST_WIDTH'(1)) begin
                            master_write <= 1'b0;
                            ctrl_busy    <= 1'b0;
                            ctrl_done    <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            beat_cnt <= beat_cnt + BURST_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    // A start level held high must be released before the next burst.
                    if (!ctrl_start) begin
                        ctrl_done <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
